// File: rtl/eff_pkg.sv
// Shared types and helpers for the modulated-delay effect controllers.
//   sweep_state_t : engage/bypass sequencing states
//   mix_max()     : full-scale value of an unsigned coefficient of width w
//   sat_add()     : unsigned add clamped to a ceiling
package eff_pkg;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    FADE_IN  = 2'd1,
    RUN      = 2'd2,
    FADE_OUT = 2'd3
  } sweep_state_t;

  function automatic int unsigned mix_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // The sum is formed one bit wider so the clamp never sees a wrapped value.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[31:0];
  endfunction

endpackage

// File: rtl/tri_lfo.sv
// Triangle LFO: phase accumulator with modulo wrap, synchronous clear and
// triangle fold of the top phase bits.
//   clk, rst : system clock, synchronous active-high reset
//   step     : advance phase by rate this cycle
//   clear    : force phase to 0 (wins over step)
//   rate     : unsigned phase increment
//   tri_o    : folded triangle, 0..2**DEL_WIDTH-1, from the current phase
// The output is named tri_o because tri is a reserved net type keyword.
module tri_lfo
  import eff_pkg::*;
#(
  parameter int unsigned DEL_WIDTH   = 9,
  parameter int unsigned PHASE_WIDTH = 24,
  parameter int unsigned RATE_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  input  logic                  clear,
  input  logic [RATE_WIDTH-1:0] rate,
  output logic [DEL_WIDTH-1:0]  tri_o
);

  logic [PHASE_WIDTH-1:0] r_phase;
  logic [DEL_WIDTH-1:0]   w_t;

  // Accumulator wraps naturally at 2**PHASE_WIDTH.
  always_ff @(posedge clk) begin
    if (rst || clear)
      r_phase <= '0;
    else if (step)
      r_phase <= r_phase + {{(PHASE_WIDTH-RATE_WIDTH){1'b0}}, rate};
  end

  // Bits below the MSB form the ramp; the MSB selects rising/falling half.
  assign w_t   = r_phase[PHASE_WIDTH-2 -: DEL_WIDTH];
  assign tri_o = r_phase[PHASE_WIDTH-1] ? ~w_t : w_t;

endmodule

// File: rtl/mod_sweep_ctrl.sv
// Sweep/engage controller for flanger and chorus.
// Produces a per-sample delay tap from a triangle LFO scaled by depth around
// a centre, and a wet-mix coefficient that ramps on engage/bypass.
//   clk, rst : system clock, synchronous active-high reset
//   en       : engage request (level)
//   vld_i    : one-cycle strobe per audio sample
//   rate     : LFO phase increment per sample
//   depth    : sweep depth, 2**DEL_WIDTH = unity
//   center   : base delay
//   del_o    : registered delay tap (holds while OFF)
//   mix_o    : registered wet gain, 0..MIX_MAX
//   vld_o    : vld_i delayed one cycle
//   busy_o   : fading in or out
module mod_sweep_ctrl
  import eff_pkg::*;
#(
  parameter int unsigned DEL_WIDTH   = 9,
  parameter int unsigned PHASE_WIDTH = 24,
  parameter int unsigned RATE_WIDTH  = 16,
  parameter int unsigned MIX_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 vld_i,
  input  logic [RATE_WIDTH-1:0] rate,
  input  logic [DEL_WIDTH:0]   depth,
  input  logic [DEL_WIDTH-1:0] center,
  output logic [DEL_WIDTH-1:0] del_o,
  output logic [MIX_WIDTH-1:0] mix_o,
  output logic                 vld_o,
  output logic                 busy_o
);

  localparam logic [MIX_WIDTH-1:0] MIX_MAX = MIX_WIDTH'(mix_max(MIX_WIDTH));
  localparam logic [DEL_WIDTH-1:0] DEL_MAX = {DEL_WIDTH{1'b1}};
  localparam int unsigned          PROD_W  = 2*DEL_WIDTH + 1;

  sweep_state_t         r_state, w_dir, w_state_nxt;
  logic [MIX_WIDTH-1:0] r_mix, w_mix_nxt;
  logic [DEL_WIDTH-1:0] r_del, w_del, w_tri;
  logic [DEL_WIDTH:0]   w_off;
  logic                 r_vld, w_step, w_clear;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= OFF;
    else     r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  // w_dir applies the en-driven transitions first; a sample strobe arriving
  // in the same cycle steps the mix in this new direction.
  always_comb begin
    w_dir = r_state;
    case (r_state)
      OFF:          if (en)  w_dir = FADE_IN;
      FADE_IN, RUN: if (!en) w_dir = FADE_OUT;
      FADE_OUT:     if (en)  w_dir = FADE_IN;
      default:      w_dir = OFF;
    endcase
  end

  always_comb begin
    w_mix_nxt = r_mix;
    if (vld_i) begin
      case (w_dir)
        FADE_IN:  if (r_mix != MIX_MAX) w_mix_nxt = r_mix + MIX_WIDTH'(1);
        FADE_OUT: if (r_mix != '0)      w_mix_nxt = r_mix - MIX_WIDTH'(1);
        RUN:      w_mix_nxt = MIX_MAX;
        default:  w_mix_nxt = '0;
      endcase
    end
  end

  // Completion is judged on the post-step mix so state and mix_o settle
  // together (mix_o=MIX_MAX appears with RUN, mix_o=0 with OFF).
  always_comb begin
    w_state_nxt = w_dir;
    case (w_dir)
      FADE_IN:  if (w_mix_nxt == MIX_MAX) w_state_nxt = RUN;
      FADE_OUT: if (w_mix_nxt == '0)      w_state_nxt = OFF;
      default:  ;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_o = (r_state == FADE_IN) || (r_state == FADE_OUT);
  end

  // ---------------- LFO ----------------
  assign w_step  = vld_i && (w_dir != OFF);
  assign w_clear = (w_state_nxt == OFF);

  tri_lfo #(
    .DEL_WIDTH   (DEL_WIDTH),
    .PHASE_WIDTH (PHASE_WIDTH),
    .RATE_WIDTH  (RATE_WIDTH)
  ) u_lfo (
    .clk   (clk),
    .rst   (rst),
    .step  (w_step),
    .clear (w_clear),
    .rate  (rate),
    .tri_o (w_tri)
  );

  // ---------------- tap scaling ----------------
  // tri (DEL_WIDTH) * depth (DEL_WIDTH+1) fits PROD_W; >> DEL_WIDTH leaves
  // an offset that can exceed the buffer, hence the clamped add.
  assign w_off = (DEL_WIDTH+1)'((PROD_W'(w_tri) * PROD_W'(depth)) >> DEL_WIDTH);
  assign w_del = DEL_WIDTH'(sat_add(32'(center), 32'(w_off), 32'(DEL_MAX)));

  // ---------------- output registers ----------------
  // Tap uses the pre-increment phase; depth/center only matter on strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mix <= '0;
      r_del <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= vld_i;
      r_mix <= w_mix_nxt;
      if (w_step) r_del <= w_del;
    end
  end

  assign del_o = r_del;
  assign mix_o = r_mix;
  assign vld_o = r_vld;

endmodule

// File: tb/tb_mod_sweep_ctrl.sv
module tb_mod_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, vld_i;
  logic [15:0] rate;
  logic [9:0]  depth;
  logic [8:0]  center;
  logic [8:0]  del_o;
  logic [7:0]  mix_o;
  logic        vld_o, busy_o;

  int n_pass = 0;
  int n_chk  = 0;
  bit chk_en = 1'b0;

  mod_sweep_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .vld_i  (vld_i),
    .rate   (rate),
    .depth  (depth),
    .center (center),
    .del_o  (del_o),
    .mix_o  (mix_o),
    .vld_o  (vld_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Mix walks one step per strobe toward en ? 255 : 0. The controller is idle
  // exactly when mix is 0 and en was low at the previous edge; busy is "mix
  // not yet at the target set by the last sampled en".
  int m_mix, m_phase, m_del, m_vld, m_enp;

  function automatic int tap(input int ph, input int dp, input int ce);
    int t, tr, off;
    t   = (ph >> 14) & 511;
    tr  = (ph >= 32'h800000) ? 511 - t : t;
    off = (tr * dp) >> 9;
    return (ce + off > 511) ? 511 : ce + off;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mix = 0; m_phase = 0; m_del = 0; m_vld = 0; m_enp = 0;
    end else begin
      bit active;
      active = en || (m_enp != 0) || (m_mix != 0);
      m_vld  = int'(vld_i);
      if (vld_i && active) begin
        m_del   = tap(m_phase, int'(depth), int'(center));
        m_phase = (m_phase + int'(rate)) & 32'hFFFFFF;
      end
      if (vld_i) m_mix = en ? ((m_mix < 255) ? m_mix + 1 : 255)
                            : ((m_mix > 0)   ? m_mix - 1 : 0);
      if (!en && m_mix == 0) m_phase = 0;
      m_enp = int'(en);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model vld_o",  int'(vld_o),  m_vld);
      chk("model mix_o",  int'(mix_o),  m_mix);
      chk("model del_o",  int'(del_o),  m_del);
      chk("model busy_o", int'(busy_o), (m_mix != (m_enp != 0 ? 255 : 0)) ? 1 : 0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic strobe();
    vld_i = 1'b1; tick(); vld_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; vld_i = 1'b0;
    rate = '0; depth = '0; center = '0;
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
    chk("reset del_o",  int'(del_o),  0);
    chk("reset mix_o",  int'(mix_o),  0);
    chk("reset vld_o",  int'(vld_o),  0);
    chk("reset busy_o", int'(busy_o), 0);

    // Fade in with a strobe every 4 clocks, phase held at 0 (rate 0).
    depth = 10'd512; en = 1'b1; tick();
    for (int i = 0; i < 255; i++) begin
      strobe();
      if (i == 0) begin
        chk("first vld_o",  int'(vld_o),  1);
        chk("first mix_o",  int'(mix_o),  1);
        chk("first busy_o", int'(busy_o), 1);
      end
      tick(); tick(); tick();
    end
    chk("fade done mix",  int'(mix_o),  255);
    chk("fade done busy", int'(busy_o), 0);
    for (int i = 0; i < 3; i++) strobe();
    chk("run hold mix", int'(mix_o), 255);

    // Back-to-back sweep in RUN from phase 0: del = 2k, peak 511, then fall.
    rate = 16'h8000; depth = 10'd512; center = 9'd0;
    for (int k = 0; k < 258; k++) begin
      strobe();
      case (k)
        0:   chk("sweep k0",   int'(del_o), 0);
        1:   chk("sweep k1",   int'(del_o), 2);
        2:   chk("sweep k2",   int'(del_o), 4);
        3:   chk("sweep k3",   int'(del_o), 6);
        255: chk("sweep k255", int'(del_o), 510);
        256: chk("sweep peak", int'(del_o), 511);
        257: chk("sweep fall", int'(del_o), 509);
        default: ;
      endcase
    end

    // Config change between strobes has no effect until the next strobe.
    rate = 16'h1234; depth = 10'd256; center = 9'd5;
    tick(); tick(); tick();
    chk("cfg hold del", int'(del_o), 509);
    strobe();
    chk("cfg new del", int'(del_o), 258);

    // Reset in RUN with a coincident strobe.
    rst = 1'b1; vld_i = 1'b1; tick();
    rst = 1'b0; vld_i = 1'b0;
    chk("midrun rst del",  int'(del_o),  0);
    chk("midrun rst mix",  int'(mix_o),  0);
    chk("midrun rst vld",  int'(vld_o),  0);
    chk("midrun rst busy", int'(busy_o), 0);
    center = 9'd7; rate = 16'h8000; depth = 10'd512;
    tick();
    strobe();
    chk("restart del", int'(del_o), 7);
    chk("restart mix", int'(mix_o), 1);

    // Saturation and fade-out / re-engage.
    rst = 1'b1; en = 1'b0; tick(); rst = 1'b0;
    center = 9'd400; depth = 10'd512; rate = 16'h8000; en = 1'b1;
    tick();
    for (int k = 0; k < 100; k++) begin
      strobe();
      if (k == 50) chk("pre-sat del", int'(del_o), 500);
      if (k == 56) chk("sat edge del", int'(del_o), 511);
    end
    chk("mix at 100", int'(mix_o), 100);
    en = 1'b0;
    strobe();
    chk("fall mix",  int'(mix_o),  99);
    chk("sat del",   int'(del_o),  511);
    chk("fall busy", int'(busy_o), 1);
    for (int j = 0; j < 49; j++) strobe();
    chk("mix at 50", int'(mix_o), 50);
    en = 1'b1;
    strobe();
    chk("reengage mix", int'(mix_o), 51);
    en = 1'b0; tick();
    for (int j = 0; j < 51; j++) strobe();
    chk("off mix",  int'(mix_o),  0);
    chk("off busy", int'(busy_o), 0);
    for (int j = 0; j < 3; j++) strobe();
    chk("off vld", int'(vld_o), 1);
    en = 1'b1;
    strobe();
    chk("phase cleared del", int'(del_o), 400);
    chk("phase cleared mix", int'(mix_o), 1);

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
